sbmx_round_ctrl: RTL and testbench
==================================

Name: sbmx_round_ctrl

Overview:
- Iterative scheduler that shares one combinational sbmx column unit (16-bit a, 16-bit s -> 16-bit c) across the four 16-bit columns of the 64-bit FUTURE state.
- Processes one column per clock over ROUNDS rounds.
- Accepts a state via a valid/ready handshake and requests round-key words by round index.
- Returns the final 64-bit state via a valid/ready handshake.
- Sits between the top-level cipher datapath and the shared sbmx instance.

Parameters:
- ROUNDS, 10, number of full rounds (1..15); each round applies sbmx to columns 0..3 in order.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  controller can accept a new state.
- in_state  input  64  [0:63], column j = bits [16j:16j+15].
- abort  input  1  synchronous abort of the current operation.
- round_idx  output  4  current round number, 0..ROUNDS-1.
- rk  input  64  round-key words for round_idx. Driven combinationally from round_idx and stable for the whole round; column j key = rk[16j:16j+15].
- col_a  output  16  to sbmx .a.
- col_s  output  16  to sbmx .s.
- col_c  input  16  from sbmx .c, same cycle.
- busy  output  1  high in RUN.
- out_valid  output  1  out_state is valid.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  64  [0:63] final state.

Behaviour:
- States: IDLE, RUN, DONE. Reset (async, rst=1) forces:
  - state IDLE
  - in_ready=1 (after release)
  - busy=0, out_valid=0
  - out_state=0, round_idx=0, col_a=0, col_s=0
  - internal state register=0, column counter=0
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load in_state into the state register, col=0, round=0, go to RUN.
  - in_ready=0 in every other state.
- RUN:
  - col_a = state column col; col_s = rk column col; both are combinational from registers, and held at 0 outside RUN.
  - On each edge, col_c is written into state column col in place, and col increments.
  - When col=3, col wraps to 0 and round increments.
  - When col=3 and round=ROUNDS-1, capture the final state (including this cycle's col_c) into out_state and go to DONE.
- DONE:
  - out_valid=1; out_state is held stable until out_valid&out_ready.
  - Then go to IDLE: out_valid=0 and in_ready=1 on the next cycle. No same-cycle reload.
- Latency: the handshake edge at cycle T is followed by RUN cycles T+1..T+4*ROUNDS. out_valid rises at T+4*ROUNDS+1, i.e. 41 cycles for ROUNDS=10.
- round_idx equals the round counter in RUN and 0 otherwise. rk is sampled only in RUN.
- abort:
  - In RUN or DONE, return to IDLE on the next edge with out_valid=0; out_state keeps its last value.
  - In IDLE it has no effect and has priority over in_valid: abort&in_valid in IDLE means no load.
- out_ready in IDLE/RUN is ignored. in_valid outside IDLE is ignored; the value is not latched.
- rst asserted mid-RUN: immediate return to the reset values; the partial result is lost.
- No arithmetic is performed in the controller. Counters are 2-bit (col) and 4-bit (round). There are no width extensions.

Test Plan:
- Bench uses a stub sbmx with c = a ^ s.
- ROUNDS=1, in_state=64'h1244_0000_ffff_00ff, rk=64'hffff_ffff_ffff_ffff:
  - col_a sequence is 1244,0000,ffff,00ff with col_s=ffff.
  - out_state=64'hedbb_ffff_0000_ff00.
  - out_valid at handshake+5.
- ROUNDS=10, constant rk=64'h0123_4567_89ab_cdef, in_state=64'hdead_beef_cafe_f00d:
  - out_state=64'hdead_beef_cafe_f00d (even XOR count).
  - out_valid at handshake+41.
  - round_idx steps 0..9, 4 cycles each.
- rk driven as {round_idx replicated ×16 nibbles}, ROUNDS=3, state 0:
  - out_state=64'h3333_3333_3333_3333 (0^1^2 per nibble).
- Hold out_ready=0 for 20 cycles in DONE:
  - out_valid and out_state stay stable, in_ready=0.
  - Then out_ready=1 for 1 cycle: IDLE next cycle, in_ready=1.
- abort at RUN cycle 6 → IDLE next cycle, busy=0, out_valid never asserted. A new in_valid is then accepted normally.
- rst pulse mid-RUN (asynchronous, between edges) → busy=0, col_a=0, in_ready=1 after release. Subsequent ROUNDS=1 run matches the first scenario.

Source files
------------

// File: rtl/sbmx_round_ctrl.sv
// Iterative round controller: walks the four 16-bit columns of a 64-bit state
// through one shared sbmx column unit, ROUNDS times, with valid/ready on both ends.
module sbmx_round_ctrl #(
  parameter int ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_state,
  input  logic        abort,
  output logic [3:0]  round_idx,
  input  logic [0:63] rk,
  output logic [15:0] col_a,
  output logic [15:0] col_s,
  input  logic [15:0] col_c,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_state,
  output logic [1:0]  dbg_state
);

  // Handshake rule (both ports): a transfer happens on the rising edge where
  // valid and ready are both high; valid/ready are never combinationally
  // dependent on the partner's signal, and in_ready/out_valid depend only on state.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [0:63] st_q, st_d;
  logic [0:63] out_q, out_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [5:0]  col_base;

  // Column j occupies bits [16j:16j+15]; column 0 is the most significant word.
  assign col_base  = {col_q, 4'b0000};
  assign out_state = out_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    out_d     = out_q;
    col_d     = col_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    round_idx = 4'd0;
    col_a     = 16'd0;
    col_s     = 16'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // abort outranks a simultaneous load request
        if (in_valid && !abort) begin
          st_d    = in_state;
          col_d   = 2'd0;
          rnd_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        round_idx = rnd_q;
        col_a     = st_q[col_base +: 16];
        col_s     = rk[col_base +: 16];
        if (abort) begin
          state_d = IDLE;
        end else begin
          st_d[col_base +: 16] = col_c;
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) begin
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == LAST_RND) begin
              // final capture includes the column written this cycle
              out_d   = st_d;
              rnd_d   = 4'd0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      out_q   <= '0;
      col_q   <= 2'd0;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      out_q   <= out_d;
      col_q   <= col_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_sbmx_round_ctrl.sv
// Bench for sbmx_round_ctrl: three instances (ROUNDS = 1, 10, 3) each wired to
// an XOR stub column unit, checked against a whole-state XOR reference model.
module tb_sbmx_round_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [0:63] in_state = '0;
  logic [0:63] rk_const = '0;
  logic        rk_mode = 1'b0;
  int          sel = 0;

  logic        in_valid_w  [3];
  logic        abort_w     [3];
  logic        out_ready_w [3];
  logic        in_ready_w  [3];
  logic        busy_w      [3];
  logic        out_valid_w [3];
  logic [3:0]  round_idx_w [3];
  logic [0:63] rk_w        [3];
  logic [0:63] out_state_w [3];
  logic [15:0] col_a_w     [3];
  logic [15:0] col_s_w     [3];
  logic [15:0] col_c_w     [3];
  logic [1:0]  dbg_w       [3];

  int n_vec = 0;
  int n_err = 0;
  logic [0:63] last_out [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int R = (g == 0) ? 1 : ((g == 1) ? 10 : 3);
    assign in_valid_w[g]  = in_valid && (sel == g);
    assign abort_w[g]     = abort && (sel == g);
    assign out_ready_w[g] = out_ready && (sel == g);
    assign col_c_w[g]     = col_a_w[g] ^ col_s_w[g];
    assign rk_w[g]        = rk_mode ? {16{round_idx_w[g]}} : rk_const;
    sbmx_round_ctrl #(.ROUNDS(R)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_w[g]),
      .in_ready  (in_ready_w[g]),
      .in_state  (in_state),
      .abort     (abort_w[g]),
      .round_idx (round_idx_w[g]),
      .rk        (rk_w[g]),
      .col_a     (col_a_w[g]),
      .col_s     (col_s_w[g]),
      .col_c     (col_c_w[g]),
      .busy      (busy_w[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready_w[g]),
      .out_state (out_state_w[g]),
      .dbg_state (dbg_w[g])
    );
  end

  function automatic int rounds_of(input int inst);
    return (inst == 0) ? 1 : ((inst == 1) ? 10 : 3);
  endfunction

  function automatic logic [0:63] key_of(input bit mode, input logic [0:63] rkc, input int r);
    return mode ? {16{4'(r)}} : rkc;
  endfunction

  // With an XOR column unit every round just XORs the whole round key in.
  function automatic logic [0:63] model(input int rounds, input bit mode,
                                        input logic [0:63] rkc, input logic [0:63] s);
    logic [0:63] acc;
    acc = s;
    for (int r = 0; r < rounds; r++) acc = acc ^ key_of(mode, rkc, r);
    return acc;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input int inst, input bit mode, input logic [0:63] rkc,
                         input logic [0:63] st, input logic [0:63] exp, input int hold);
    int          rounds;
    int          n;
    int          c;
    bit          seen;
    logic [0:63] m;
    logic [0:63] kk;
    rounds = rounds_of(inst);
    @(negedge clk);
    sel = inst; rk_mode = mode; rk_const = rkc; in_state = st; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready_w[inst]), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    m = st; n = 1; seen = 1'b0;
    while (!seen && n < 4 * rounds + 8) begin
      if (out_valid_w[inst]) begin
        seen = 1'b1;
      end else if (n <= 4 * rounds) begin
        c  = n - 1;
        kk = key_of(mode, rkc, c / 4);
        chk("busy_run", 64'(busy_w[inst]), 64'd1);
        chk("round_idx", 64'(round_idx_w[inst]), 64'(c / 4));
        chk("col_s", 64'(col_s_w[inst]), 64'(kk[16 * (c % 4) +: 16]));
        chk("col_a", 64'(col_a_w[inst]), 64'(m[16 * (c % 4) +: 16]));
        m[16 * (c % 4) +: 16] = m[16 * (c % 4) +: 16] ^ kk[16 * (c % 4) +: 16];
      end
      if (!seen) begin
        @(negedge clk);
        n++;
      end
    end
    chk("latency", 64'(seen ? n : -1), 64'(4 * rounds + 1));
    if (seen) begin
      chk("out_state", out_state_w[inst], exp);
      for (int h = 0; h < hold; h++) begin
        chk("hold_valid", 64'(out_valid_w[inst]), 64'd1);
        chk("hold_state", out_state_w[inst], exp);
        chk("hold_in_ready", 64'(in_ready_w[inst]), 64'd0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_valid", 64'(out_valid_w[inst]), 64'd0);
      chk("drain_in_ready", 64'(in_ready_w[inst]), 64'd1);
      last_out[inst] = exp;
    end
  endtask

  typedef struct {
    int          inst;
    bit          mode;
    logic [0:63] rkc;
    logic [0:63] st;
    logic [0:63] exp;
    int          hold;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          inst;
    bit          mode;
    logic [0:63] rkc;
    logic [0:63] st;
    bit          any_ov;

    vecs[0] = '{0, 1'b0, 64'hffff_ffff_ffff_ffff, 64'h1244_0000_ffff_00ff, 64'hedbb_ffff_0000_ff00, 0};
    vecs[1] = '{1, 1'b0, 64'h0123_4567_89ab_cdef, 64'hdead_beef_cafe_f00d, 64'hdead_beef_cafe_f00d, 2};
    vecs[2] = '{2, 1'b1, 64'h0, 64'h0, 64'h3333_3333_3333_3333, 1};
    vecs[3] = '{2, 1'b0, 64'ha5a5_5a5a_0f0f_f0f0, 64'h0, 64'ha5a5_5a5a_0f0f_f0f0, 0};
    vecs[4] = '{0, 1'b0, 64'h0000_ffff_1234_8000, 64'h1111_2222_3333_4444, 64'h1111_dddd_2107_c444, 20};
    for (int i = 0; i < 3; i++) last_out[i] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 64'(in_ready_w[i]), 64'd1);
      chk("rst_busy", 64'(busy_w[i]), 64'd0);
      chk("rst_out_valid", 64'(out_valid_w[i]), 64'd0);
      chk("rst_out_state", out_state_w[i], 64'd0);
      chk("rst_round_idx", 64'(round_idx_w[i]), 64'd0);
      chk("rst_col_a", 64'(col_a_w[i]), 64'd0);
      chk("rst_col_s", 64'(col_s_w[i]), 64'd0);
    end

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].inst, vecs[i].mode, vecs[i].rkc, vecs[i].st, vecs[i].exp, vecs[i].hold);

    // abort in the sixth RUN cycle
    @(negedge clk);
    sel = 1; rk_mode = 1'b0; rk_const = 64'h1357_9bdf_0246_8ace;
    in_state = 64'h0bad_cafe_1234_5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_busy", 64'(busy_w[1]), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy_w[1]), 64'd0);
    chk("abort_in_ready", 64'(in_ready_w[1]), 64'd1);
    chk("abort_out_valid", 64'(out_valid_w[1]), 64'd0);
    chk("abort_out_state", out_state_w[1], last_out[1]);
    any_ov = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid_w[1] || busy_w[1]) any_ov = 1'b1;
    end
    chk("abort_no_result", 64'(any_ov), 64'd0);
    // abort with in_valid while idle: no load
    in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 64'(busy_w[1]), 64'd0);
    chk("idle_abort_in_ready", 64'(in_ready_w[1]), 64'd1);
    run_txn(1, 1'b0, 64'h1357_9bdf_0246_8ace, 64'h0bad_cafe_1234_5678, 64'h0bad_cafe_1234_5678, 0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    sel = 1; rk_mode = 1'b0; rk_const = 64'hffff_0000_ffff_0000;
    in_state = 64'h8888_7777_6666_5555; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_w[1]), 64'd0);
    chk("arst_col_a", 64'(col_a_w[1]), 64'd0);
    chk("arst_out_state", out_state_w[1], 64'd0);
    chk("arst_round_idx", 64'(round_idx_w[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready_w[1]), 64'd1);
    for (int i = 0; i < 3; i++) last_out[i] = '0;
    run_txn(vecs[0].inst, vecs[0].mode, vecs[0].rkc, vecs[0].st, vecs[0].exp, 0);

    // randomized transactions against the reference model
    for (int t = 0; t < 15; t++) begin
      inst = $urandom_range(0, 2);
      mode = 1'($urandom_range(0, 1));
      rkc  = {$urandom, $urandom};
      st   = {$urandom, $urandom};
      run_txn(inst, mode, rkc, st, model(rounds_of(inst), mode, rkc, st), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
